// File: rtl/bus_master_arbiter_pkg.sv
// Shared definitions for the 68000 bus master arbiter: FSM encoding,
// hold-time default and grant-vector helpers.
package bus_master_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQUEST  = 3'd1,
    WAIT_BUS = 3'd2,
    OWNED    = 3'd3,
    RELEASE  = 3'd4
  } arb_state_e;

  localparam int unsigned MAX_HOLD_DEFAULT = 1024;
  localparam int unsigned MAX_NREQ         = 8;

  // Shifted by the winner index to build the one-hot grant.
  localparam logic [MAX_NREQ-1:0] ONEHOT_LSB = {{(MAX_NREQ-1){1'b0}}, 1'b1};

  // Index width that stays legal for a single requester.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_master_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after the
// pointer, wrapping modulo NREQ.
module bus_master_arbiter_rr_pick
  import bus_master_arbiter_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned PTR_W = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [PTR_W-1:0] idx_o,
  output logic             valid_o
);

  int unsigned      cand;
  logic [PTR_W-1:0] cand_idx;

  always_comb begin
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand     = (32'(ptr_i) + i) % NREQ;
      cand_idx = PTR_W'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        idx_o   = cand_idx;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_master_arbiter.sv
// Shares the 68000 bus between the CPU and NREQ auxiliary masters using the
// BR/BG/BGACK handshake, round-robin selection and a hold-time preempt.
module bus_master_arbiter
  import bus_master_arbiter_pkg::*;
#(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT,
  parameter int unsigned CNT_W    = 11
) (
  input  logic            CPUCLK_IN,
  input  logic            RESET_IN,
  input  logic            RUN_IN,
  input  logic            AS_IN,
  input  logic            BG_IN,
  input  logic [NREQ-1:0] REQ_IN,
  output logic            BR,
  output logic            BGACK,
  output logic [NREQ-1:0] GNT,
  output logic [NREQ-1:0] PREEMPT,
  output logic            BUSY
);

  localparam int unsigned      PTR_W      = ptr_width(NREQ);
  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

  arb_state_e       state_q;
  logic             br_q, bgack_q, busy_q;
  logic [NREQ-1:0]  gnt_q, preempt_q, gnt_d;
  logic [PTR_W-1:0] ptr_q, owner_q, ptr_d;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_valid;
  logic             owner_req, others_req;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  bus_master_arbiter_rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) rr_pick (
    .req_i   (REQ_IN),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    gnt_d      = NREQ'(ONEHOT_LSB << pick_idx);
    // The grant vector doubles as the owner mask, avoiding a variable index.
    owner_req  = |(REQ_IN & gnt_q);
    others_req = |(REQ_IN & ~gnt_q);
    cnt_d      = (cnt_q == HOLD_LIMIT) ? cnt_q : cnt_q + 1'b1;
    ptr_d      = (32'(owner_q) == NREQ - 1) ? '0 : owner_q + 1'b1;
  end

  always_ff @(posedge CPUCLK_IN) begin
    if (RESET_IN) begin
      state_q   <= IDLE;
      br_q      <= 1'b0;
      bgack_q   <= 1'b0;
      busy_q    <= 1'b0;
      gnt_q     <= '0;
      preempt_q <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else if (!RUN_IN) begin
      // Same as reset except the fairness pointer survives.
      state_q   <= IDLE;
      br_q      <= 1'b0;
      bgack_q   <= 1'b0;
      busy_q    <= 1'b0;
      gnt_q     <= '0;
      preempt_q <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|REQ_IN) begin
            state_q <= REQUEST;
            br_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        REQUEST: begin
          if (!(|REQ_IN)) begin
            state_q <= IDLE;
            br_q    <= 1'b0;
            busy_q  <= 1'b0;
          end else if (BG_IN) begin
            state_q <= WAIT_BUS;
          end
        end
        WAIT_BUS: begin
          if (!pick_valid) begin
            state_q <= IDLE;
            br_q    <= 1'b0;
            busy_q  <= 1'b0;
          end else if (!AS_IN && !bgack_q) begin
            state_q   <= OWNED;
            owner_q   <= pick_idx;
            gnt_q     <= gnt_d;
            bgack_q   <= 1'b1;
            br_q      <= 1'b0;
            cnt_q     <= '0;
            preempt_q <= '0;
          end
        end
        OWNED: begin
          if (!owner_req) begin
            state_q   <= RELEASE;
            gnt_q     <= '0;
            preempt_q <= '0;
            bgack_q   <= 1'b0;
            ptr_q     <= ptr_d;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_d;
            // Keyed on the next count so PREEMPT rises with the counter hitting the limit.
            if (cnt_d == HOLD_LIMIT && others_req) begin
              preempt_q <= gnt_q;
            end
          end
        end
        RELEASE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          br_q      <= 1'b0;
          bgack_q   <= 1'b0;
          busy_q    <= 1'b0;
          gnt_q     <= '0;
          preempt_q <= '0;
        end
      endcase
    end
  end

  assign BR      = br_q;
  assign BGACK   = bgack_q;
  assign GNT     = gnt_q;
  assign PREEMPT = preempt_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Directed bench for bus_master_arbiter with a short hold limit of 8 cycles.
module tb_bus_master_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       as_in;
  logic       bg_in;
  logic [1:0] req;
  logic       br, bgack, busy;
  logic [1:0] gnt, preempt;

  int checks = 0;
  int fails  = 0;

  bus_master_arbiter #(
    .NREQ     (2),
    .MAX_HOLD (8),
    .CNT_W    (4)
  ) dut (
    .CPUCLK_IN (clk),
    .RESET_IN  (rst),
    .RUN_IN    (run),
    .AS_IN     (as_in),
    .BG_IN     (bg_in),
    .REQ_IN    (req),
    .BR        (br),
    .BGACK     (bgack),
    .GNT       (gnt),
    .PREEMPT   (preempt),
    .BUSY      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b1; as_in = 1'b1; bg_in = 1'b0; req = 2'b00;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1; as_in = 1'b1; bg_in = 1'b0; req = 2'b00;
    tick(2);
    checks++;
    if ({br, bgack, gnt, preempt, busy} !== 7'b0) begin
      fails++; $display("FAIL reset_idle: got %b expected %b", {br, bgack, gnt, preempt, busy}, 7'b0);
    end
    rst = 1'b0; req = 2'b01; bg_in = 1'b1; as_in = 1'b0;
    tick(3);
    checks++;
    if ({bgack, gnt} !== 3'b101) begin
      fails++; $display("FAIL reset_pre_grant: got %b expected %b", {bgack, gnt}, 3'b101);
    end
    rst = 1'b1;
    tick(1);
    checks++;
    if ({br, bgack, gnt, preempt, busy} !== 7'b0) begin
      fails++; $display("FAIL reset_mid_own: got %b expected %b", {br, bgack, gnt, preempt, busy}, 7'b0);
    end
    rst = 1'b0; req = 2'b00; bg_in = 1'b0; as_in = 1'b1;
    tick(1);
    checks++;
    if ({br, busy} !== 2'b00) begin
      fails++; $display("FAIL reset_after: got %b expected %b", {br, busy}, 2'b00);
    end
  endtask

  task automatic test_single_grant();
    req = 2'b01;
    tick(1);
    checks++;
    if ({br, busy, gnt} !== 4'b1100) begin
      fails++; $display("FAIL sg_br: got %b expected %b", {br, busy, gnt}, 4'b1100);
    end
    bg_in = 1'b1; as_in = 1'b1;
    tick(3);
    checks++;
    if ({br, bgack, gnt} !== 4'b1000) begin
      fails++; $display("FAIL sg_as_block: got %b expected %b", {br, bgack, gnt}, 4'b1000);
    end
    as_in = 1'b0;
    tick(1);
    checks++;
    if ({br, bgack, gnt} !== 4'b0101) begin
      fails++; $display("FAIL sg_grant: got %b expected %b", {br, bgack, gnt}, 4'b0101);
    end
    bg_in = 1'b0;
    tick(2);
    checks++;
    if ({bgack, gnt} !== 3'b101) begin
      fails++; $display("FAIL sg_bg_low: got %b expected %b", {bgack, gnt}, 3'b101);
    end
    req = 2'b00;
    tick(1);
    checks++;
    if ({bgack, gnt, busy} !== 4'b0001) begin
      fails++; $display("FAIL sg_release: got %b expected %b", {bgack, gnt, busy}, 4'b0001);
    end
    tick(1);
    checks++;
    if ({br, bgack, busy} !== 3'b000) begin
      fails++; $display("FAIL sg_idle: got %b expected %b", {br, bgack, busy}, 3'b000);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp;
    do_reset();
    req = 2'b11; bg_in = 1'b1; as_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp = (k % 2 == 0) ? 2'b01 : 2'b10;
      tick(3);
      checks++;
      if ({bgack, br, gnt} !== {2'b10, exp}) begin
        fails++; $display("FAIL rr_grant%0d: got %b expected %b", k, {bgack, br, gnt}, {2'b10, exp});
      end
      tick(5);
      checks++;
      if (gnt !== exp) begin
        fails++; $display("FAIL rr_hold%0d: got %b expected %b", k, gnt, exp);
      end
      req = ~exp;
      tick(1);
      checks++;
      if ({bgack, gnt} !== 3'b000) begin
        fails++; $display("FAIL rr_release%0d: got %b expected %b", k, {bgack, gnt}, 3'b000);
      end
      req = 2'b11;
      tick(1);
    end
    req = 2'b00; bg_in = 1'b0; as_in = 1'b1;
    tick(1);
  endtask

  task automatic test_preempt();
    do_reset();
    req = 2'b01; bg_in = 1'b1; as_in = 1'b0;
    tick(3);
    bg_in = 1'b0;
    tick(2);
    req = 2'b11;
    for (int c = 3; c <= 7; c++) begin
      tick(1);
      checks++;
      if (preempt !== 2'b00) begin
        fails++; $display("FAIL pre_early_cnt%0d: got %b expected %b", c, preempt, 2'b00);
      end
    end
    tick(1);
    checks++;
    if ({preempt, gnt} !== 4'b0101) begin
      fails++; $display("FAIL pre_at_limit: got %b expected %b", {preempt, gnt}, 4'b0101);
    end
    tick(2);
    checks++;
    if ({preempt, gnt} !== 4'b0101) begin
      fails++; $display("FAIL pre_sticky: got %b expected %b", {preempt, gnt}, 4'b0101);
    end
    req = 2'b10;
    tick(1);
    checks++;
    if ({preempt, gnt, bgack} !== 5'b00000) begin
      fails++; $display("FAIL pre_clear: got %b expected %b", {preempt, gnt, bgack}, 5'b00000);
    end
    bg_in = 1'b1;
    tick(4);
    checks++;
    if ({preempt, gnt, bgack} !== 5'b00101) begin
      fails++; $display("FAIL pre_next_owner: got %b expected %b", {preempt, gnt, bgack}, 5'b00101);
    end
    req = 2'b00; bg_in = 1'b0; as_in = 1'b1;
    tick(2);
  endtask

  task automatic test_preempt_late();
    do_reset();
    req = 2'b01; bg_in = 1'b1; as_in = 1'b0;
    tick(3);
    bg_in = 1'b0;
    tick(12);
    checks++;
    if ({preempt, gnt} !== 4'b0001) begin
      fails++; $display("FAIL late_no_contender: got %b expected %b", {preempt, gnt}, 4'b0001);
    end
    req = 2'b11;
    tick(1);
    checks++;
    if (preempt !== 2'b01) begin
      fails++; $display("FAIL late_saturated: got %b expected %b", preempt, 2'b01);
    end
    req = 2'b10;
    tick(1);
    checks++;
    if ({preempt, bgack} !== 3'b000) begin
      fails++; $display("FAIL late_clear: got %b expected %b", {preempt, bgack}, 3'b000);
    end
    req = 2'b00; as_in = 1'b1;
    tick(2);
  endtask

  task automatic test_withdrawal();
    do_reset();
    req = 2'b01;
    tick(2);
    checks++;
    if ({br, busy} !== 2'b11) begin
      fails++; $display("FAIL wd_request: got %b expected %b", {br, busy}, 2'b11);
    end
    req = 2'b00;
    tick(1);
    checks++;
    if ({br, busy, gnt, bgack} !== 5'b00000) begin
      fails++; $display("FAIL wd_request_drop: got %b expected %b", {br, busy, gnt, bgack}, 5'b00000);
    end
    bg_in = 1'b1;
    tick(2);
    checks++;
    if ({br, busy, gnt, bgack} !== 5'b00000) begin
      fails++; $display("FAIL wd_stray_bg: got %b expected %b", {br, busy, gnt, bgack}, 5'b00000);
    end
    req = 2'b01;
    tick(2);
    req = 2'b00;
    tick(1);
    checks++;
    if ({br, busy, gnt, bgack} !== 5'b00000) begin
      fails++; $display("FAIL wd_wait_drop: got %b expected %b", {br, busy, gnt, bgack}, 5'b00000);
    end
    bg_in = 1'b0;
  endtask

  task automatic test_run_low();
    do_reset();
    run = 1'b0; req = 2'b11; bg_in = 1'b1; as_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      checks++;
      if ({br, busy, bgack} !== 3'b000) begin
        fails++; $display("FAIL run_low_idle%0d: got %b expected %b", i, {br, busy, bgack}, 3'b000);
      end
    end
    run = 1'b1;
    tick(3);
    checks++;
    if ({bgack, gnt} !== 3'b101) begin
      fails++; $display("FAIL run_grant: got %b expected %b", {bgack, gnt}, 3'b101);
    end
    run = 1'b0;
    tick(1);
    checks++;
    if ({br, bgack, gnt, preempt, busy} !== 7'b0) begin
      fails++; $display("FAIL run_drop_owned: got %b expected %b", {br, bgack, gnt, preempt, busy}, 7'b0);
    end
    run = 1'b1;
    tick(3);
    req = 2'b10;
    tick(1);
    run = 1'b0; req = 2'b11;
    tick(2);
    run = 1'b1;
    tick(3);
    checks++;
    if ({bgack, gnt} !== 3'b110) begin
      fails++; $display("FAIL run_ptr_kept: got %b expected %b", {bgack, gnt}, 3'b110);
    end
    req = 2'b00; bg_in = 1'b0; as_in = 1'b1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_round_robin();
    test_preempt();
    test_preempt_late();
    test_withdrawal();
    test_run_low();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
